// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receiver and frame checker feeding a small output FIFO.
// Frames are decoded from the resynchronised rx line with a runtime bit period.
// Each decoded word is queued together with its frame and parity error flags.
// Optional feature macro: UART_RX_BREAK_DET_EN. When it is defined, a break
// (all data bits and all stop slots low) is reported on break_det and is not queued.
module uart_rx_monitor #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [31:0]                 cfg_divider,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        out_data,
  output logic                        out_frame_err,
  output logic                        out_parity_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
`ifdef UART_RX_BREAK_DET_EN
  output logic                        break_det,
`endif
  output logic [2:0]                  dbg_state
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              EW         = DATA_BITS + 2;
  localparam logic [3:0]      LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP  = 4'(STOP_BITS - 1);
  localparam logic            PAR_ODD    = (PARITY == 1);
  localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_prev_q;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Resynchronise the asynchronous line; keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic [31:0]          div_q;
  logic [31:0]          cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 armed_q;
`ifdef UART_RX_BREAK_DET_EN
  logic                 stop_low_q;
  logic                 break_q;
  logic                 is_break;
`endif

  logic [31:0] div_eff;
  logic        start_edge;
  logic        tick;
  logic        last_stop;
  logic        frame_err_now;
  logic        push;

  // Bit periods shorter than 4 clocks cannot be centred, so clamp them.
  assign div_eff       = (cfg_divider < 32'd4) ? 32'd4 : cfg_divider;
  assign start_edge    = armed_q & rxs_prev_q & ~rxs;
  assign tick          = (cnt_q == 32'd0);
  assign last_stop     = (state_q == S_STOP) && tick && (bit_q == LAST_STOP);
  assign frame_err_now = frm_err_q | ~rxs;

`ifdef UART_RX_BREAK_DET_EN
  assign is_break = (shreg_q == '0) && stop_low_q && ~rxs;
  assign push     = last_stop && !is_break;
`else
  assign push     = last_stop;
`endif

  // Frame sequencing: cnt_q counts down to the centre of the next bit slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      div_q      <= 32'd4;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      armed_q    <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
      stop_low_q <= 1'b0;
      break_q    <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DET_EN
      break_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          // After a framing error the line must return high before a new start is taken.
          if (rxs) armed_q <= 1'b1;
          if (start_edge) begin
            state_q    <= S_START;
            div_q      <= div_eff;
            cnt_q      <= (div_eff >> 1) - 32'd1;
            bit_q      <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            stop_low_q <= 1'b1;
`endif
          end
        end
        S_START: begin
          if (!tick) begin
            cnt_q <= cnt_q - 32'd1;
          end else if (rxs) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DATA;
            cnt_q   <= div_q - 32'd1;
          end
        end
        S_DATA: begin
          if (!tick) begin
            cnt_q <= cnt_q - 32'd1;
          end else begin
            cnt_q   <= div_q - 32'd1;
            shreg_q <= {rxs, shreg_q[DATA_BITS-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (!tick) begin
            cnt_q <= cnt_q - 32'd1;
          end else begin
            par_err_q <= (((^shreg_q) ^ rxs) != PAR_ODD);
            cnt_q     <= div_q - 32'd1;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (!tick) begin
            cnt_q <= cnt_q - 32'd1;
          end else if (bit_q == LAST_STOP) begin
            state_q   <= S_IDLE;
            frm_err_q <= frame_err_now;
            if (frame_err_now) armed_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_q   <= is_break;
`endif
          end else begin
            cnt_q      <= div_q - 32'd1;
            bit_q      <= bit_q + 4'd1;
            frm_err_q  <= frame_err_now;
`ifdef UART_RX_BREAK_DET_EN
            stop_low_q <= stop_low_q & ~rxs;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
`ifdef UART_RX_BREAK_DET_EN
  assign break_det = break_q;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // Handshake: the head entry is offered while out_valid is high and is consumed
  // on every rising edge where out_valid && out_ready; the head and its flags
  // stay stable until that edge. A word pushed into an empty FIFO appears on
  // the next cycle (no bypass).
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overrun_q;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [EW-1:0] push_word;
  logic [EW-1:0] head;

  assign push_word = {shreg_q, frame_err_now, par_err_q};
  assign full      = (count_q == FULL_LEVEL);
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign head      = mem_q[rd_ptr_q];

  // Storage, pointers and level; a push into a full FIFO without a pop is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push & full & ~pop;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_data       = head[EW-1:2];
  assign out_frame_err  = head[1];
  assign out_parity_err = head[0];
  assign out_valid      = (count_q != '0);
  assign fifo_level     = count_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Testbench for uart_rx_monitor: instance A is the default 8N1 / depth-4 build,
// instance B is 7 data bits, even parity, 2 stop bits, depth 2, 3 sync stages.
module tb_uart_rx_monitor;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] cfg_divider;
  logic        rx_a, rx_b;

  always #5 clk = ~clk;

  // ---------------- DUT A signals ----------------
  logic [7:0] out_data_a;
  logic       out_frame_err_a, out_parity_err_a, out_valid_a, out_ready_a;
  logic       overrun_a, busy_a;
  logic [2:0] fifo_level_a;
  logic [2:0] dbg_state_a;

  // ---------------- DUT B signals ----------------
  logic [6:0] out_data_b;
  logic       out_frame_err_b, out_parity_err_b, out_valid_b, out_ready_b;
  logic       overrun_b, busy_b;
  logic [1:0] fifo_level_b;
  logic [2:0] dbg_state_b;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_det_a, break_det_b;
`endif

  uart_rx_monitor u_dut_a (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_divider   (cfg_divider),
    .rx            (rx_a),
    .out_data      (out_data_a),
    .out_frame_err (out_frame_err_a),
    .out_parity_err(out_parity_err_a),
    .out_valid     (out_valid_a),
    .out_ready     (out_ready_a),
    .overrun       (overrun_a),
    .fifo_level    (fifo_level_a),
    .busy          (busy_a),
`ifdef UART_RX_BREAK_DET_EN
    .break_det     (break_det_a),
`endif
    .dbg_state     (dbg_state_a)
  );

  uart_rx_monitor #(
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2), .SYNC_STAGES(3)
  ) u_dut_b (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_divider   (cfg_divider),
    .rx            (rx_b),
    .out_data      (out_data_b),
    .out_frame_err (out_frame_err_b),
    .out_parity_err(out_parity_err_b),
    .out_valid     (out_valid_b),
    .out_ready     (out_ready_b),
    .overrun       (overrun_b),
    .fifo_level    (fifo_level_b),
    .busy          (busy_b),
`ifdef UART_RX_BREAK_DET_EN
    .break_det     (break_det_b),
`endif
    .dbg_state     (dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rise_a = -1;
  logic       vprev_a = 1'b0;
  int         ovr_cnt_a = 0, exp_ovr_a = 0;
  int         ovr_cnt_b = 0;
  int         brk_cnt_a = 0, exp_brk_a = 0;
  int         brk_cnt_b = 0;
  logic [9:0] exp_a_q[$];
  logic [8:0] exp_b_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorders sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid_a && !vprev_a) rise_a = cyc;
    vprev_a = out_valid_a;
    if (overrun_a) ovr_cnt_a++;
    if (overrun_b) ovr_cnt_b++;
`ifdef UART_RX_BREAK_DET_EN
    if (break_det_a) brk_cnt_a++;
    if (break_det_b) brk_cnt_b++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input int which, input logic b, input int d);
    if (which == 0) rx_a = b; else rx_b = b;
    repeat (d) @(negedge clk);
  endtask

  // Start bit, data LSB first, optional parity, stop slots, then one idle-high slot.
  task automatic send_frame(input int which, input int d, input logic [8:0] data,
                            input int nbits, input bit has_par, input logic par_bit,
                            input int nstop, input logic [1:0] stop_vals, input bit scramble);
    drive_bit(which, 1'b0, d);
    if (scramble) cfg_divider = $urandom_range(4, 300);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i], d);
    if (has_par) drive_bit(which, par_bit, d);
    for (int i = 0; i < nstop; i++) drive_bit(which, stop_vals[i], d);
    drive_bit(which, 1'b1, d);
  endtask

  // ---------------- reference models ----------------
  // A: 8 data bits, no parity, one stop slot, 4 entries.
  task automatic model_a(input logic [7:0] data, input logic stop);
`ifdef UART_RX_BREAK_DET_EN
    if (data == 8'h00 && !stop) begin
      exp_brk_a++;
      return;
    end
`endif
    if (exp_a_q.size() < 4) exp_a_q.push_back({data, ~stop, 1'b0});
    else exp_ovr_a++;
  endtask

  // B: 7 data bits, even parity (data ones + parity bit must be even), two stop slots.
  task automatic model_b(input logic [6:0] data, input logic pbit, input logic [1:0] stops);
    logic perr, ferr;
    perr = ((^data) ^ pbit) != 1'b0;
    ferr = (stops != 2'b11);
    if (exp_b_q.size() < 2) exp_b_q.push_back({data, ferr, perr});
  endtask

  task automatic drain_a(input string tag);
    while (exp_a_q.size() > 0) begin
      logic [9:0] w;
      int k;
      w = exp_a_q.pop_front();
      k = 0;
      while (!out_valid_a && k < 200) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_valid"}, 32'(out_valid_a), 32'd1);
      check({tag, "_word"}, 32'({out_data_a, out_frame_err_a, out_parity_err_a}), 32'(w));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check({tag, "_hold"}, 32'({out_data_a, out_frame_err_a, out_parity_err_a}), 32'(w));
      out_ready_a = 1'b1;
      @(negedge clk);
      out_ready_a = 1'b0;
    end
    check({tag, "_empty"}, 32'({out_valid_a, fifo_level_a}), 32'd0);
  endtask

  task automatic drain_b(input string tag);
    while (exp_b_q.size() > 0) begin
      logic [8:0] w;
      int k;
      w = exp_b_q.pop_front();
      k = 0;
      while (!out_valid_b && k < 200) begin
        @(negedge clk);
        k++;
      end
      check({tag, "_valid"}, 32'(out_valid_b), 32'd1);
      check({tag, "_word"}, 32'({out_data_b, out_frame_err_b, out_parity_err_b}), 32'(w));
      out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_b = 1'b0;
    end
    check({tag, "_empty"}, 32'({out_valid_b, fifo_level_b}), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int start_cyc;
    int lat;
    int nom;

    resetn      = 1'b0;
    rx_a        = 1'b1;
    rx_b        = 1'b1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    cfg_divider = 32'd106;
    repeat (5) @(negedge clk);

    // Reset values.
    check("rst_a_level", 32'(fifo_level_a), 32'd0);
    check("rst_a_flags", 32'({out_valid_a, overrun_a, busy_a}), 32'd0);
    check("rst_a_head", 32'({out_data_a, out_frame_err_a, out_parity_err_a}), 32'd0);
    check("rst_b_all", 32'({out_valid_b, busy_b, fifo_level_b, out_data_b, out_frame_err_b, out_parity_err_b}), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'({busy_a, out_valid_a, busy_b}), 32'd0);

    // 0x55 at D=106 with latency window H+9D+1 +/- SYNC_STAGES.
    start_cyc = cyc;
    rise_a    = -1;
    send_frame(0, 106, 9'h055, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    model_a(8'h55, 1'b1);
    lat = rise_a - start_cyc - 1;
    nom = 106 / 2 + 9 * 106 + 1;
    check("latency_window", 32'(lat >= nom - 2 && lat <= nom + 2), 32'd1);
    check("level_one", 32'(fifo_level_a), 32'd1);
    drain_a("t55");

    // False start: 30-clock low pulse.
    rx_a = 1'b0;
    repeat (10) @(negedge clk);
    check("false_start_busy", 32'(busy_a), 32'd1);
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (106) @(negedge clk);
    check("false_start_idle", 32'({busy_a, fifo_level_a}), 32'd0);

    // Frame error on 0xA3, then a clean 0x01.
    send_frame(0, 106, 9'h0A3, 8, 1'b0, 1'b0, 1, 2'b00, 1'b0);
    model_a(8'hA3, 1'b0);
    send_frame(0, 106, 9'h001, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    model_a(8'h01, 1'b1);
    drain_a("ferr");

    // Overrun: five frames with the consumer stalled.
    ovr_cnt_a = 0;
    exp_ovr_a = 0;
    for (int v = 16; v <= 20; v++) begin
      send_frame(0, 106, 9'(v), 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
      model_a(8'(v), 1'b1);
    end
    check("ovr_level", 32'(fifo_level_a), 32'(exp_a_q.size()));
    check("ovr_pulses", 32'(ovr_cnt_a), 32'(exp_ovr_a));
    drain_a("ovr");

    // Continuous low line for 3*D*10 clocks, then idle.
    rx_a = 1'b0;
    repeat (3 * 106 * 10) @(negedge clk);
    rx_a = 1'b1;
    repeat (300) @(negedge clk);
    model_a(8'h00, 1'b0);
    check("break_level", 32'(fifo_level_a), 32'(exp_a_q.size()));
`ifdef UART_RX_BREAK_DET_EN
    check("break_pulses", 32'(brk_cnt_a), 32'(exp_brk_a));
`endif
    drain_a("brk");

    // Reset mid-frame flushes the FIFO and never emits a partial word.
    send_frame(0, 106, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    drive_bit(0, 1'b0, 106);
    drive_bit(0, 1'b1, 106);
    drive_bit(0, 1'b0, 106);
    check("mid_busy", 32'(busy_a), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("mid_rst", 32'({out_valid_a, busy_a, fifo_level_a, out_data_a}), 32'd0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_a_q.delete();
    repeat (1200) @(negedge clk);
    check("mid_no_partial", 32'({out_valid_a, fifo_level_a}), 32'd0);
    send_frame(0, 106, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    model_a(8'h3C, 1'b1);
    drain_a("post_mid");

    // Randomised frames on A: short dividers, clamped dividers, mid-frame divider changes.
    for (int n = 0; n < 6; n++) begin
      int d;
      logic [7:0] v;
      logic s;
      bit scr;
      if ($urandom_range(0, 3) == 0) begin
        cfg_divider = $urandom_range(0, 3);
        d = 4;
      end else begin
        d = $urandom_range(8, 40);
        cfg_divider = 32'(d);
      end
      v   = 8'($urandom);
      s   = ($urandom_range(0, 3) != 0);
      scr = 1'($urandom_range(0, 1));
      send_frame(0, d, {1'b0, v}, 8, 1'b0, 1'b0, 1, {1'b1, s}, scr);
      model_a(v, s);
      drain_a("rand_a");
    end

    // Instance B: even parity with 7 data bits and two stop slots.
    cfg_divider = 32'd20;
    send_frame(1, 20, 9'h041, 7, 1'b1, 1'b1, 2, 2'b11, 1'b0);
    model_b(7'h41, 1'b1, 2'b11);
    drain_b("par_bad");
    send_frame(1, 20, 9'h041, 7, 1'b1, 1'b0, 2, 2'b11, 1'b0);
    model_b(7'h41, 1'b0, 2'b11);
    drain_b("par_ok");
    send_frame(1, 20, 9'h02A, 7, 1'b1, 1'b1, 2, 2'b11, 1'b0);
    model_b(7'h2A, 1'b1, 2'b11);
    drain_b("par_odd_data");
    send_frame(1, 20, 9'h07F, 7, 1'b1, 1'b1, 2, 2'b01, 1'b0);
    model_b(7'h7F, 1'b1, 2'b01);
    drain_b("stop2_low");
    for (int n = 0; n < 3; n++) begin
      logic [6:0] v;
      logic p;
      logic [1:0] st;
      int d;
      d  = $urandom_range(6, 30);
      cfg_divider = 32'(d);
      v  = 7'($urandom);
      p  = 1'($urandom_range(0, 1));
      st = {1'($urandom_range(0, 1)), 1'b1};
      send_frame(1, d, {2'b00, v}, 7, 1'b1, p, 2, st, 1'b0);
      model_b(v, p, st);
      drain_b("rand_b");
    end
    check("b_no_overrun", 32'(ovr_cnt_b), 32'd0);
`ifdef UART_RX_BREAK_DET_EN
    check("b_no_break", 32'(brk_cnt_b), 32'd0);
    check("a_break_total", 32'(brk_cnt_a), 32'(exp_brk_a));
`endif
    check("a_overrun_total", 32'(ovr_cnt_a), 32'(exp_ovr_a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
